// File: rtl/sve_pkg.sv
// sve_pkg: shared limits, opcodes and saturation helper for signed_value_entry
package sve_pkg;
  localparam logic signed [7:0] C_MAX = 8'sd127;
  localparam logic signed [7:0] C_MIN = -8'sd127;
  localparam logic signed [7:0] C_ZERO = 8'sd0;
  typedef enum logic [2:0] {OP_NONE, OP_CLR, OP_LD, OP_INC, OP_DEC} op_t;
  function automatic logic [7:0] clamp9(input logic signed [8:0] v);
    return v > 9'sd127 ? C_MAX : v < -9'sd127 ? C_MIN : v[7:0];
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce, rising-edge pulse and optional auto-repeat for one button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic s1, s2, lvl, arm, acc, lvl_n, hit;
  logic [1:0] v;
  logic [DW-1:0] cnt;
  logic [HW-1:0] rc;
  // arm only after a synced low is seen, so a button held across reset never fires
  assign acc = arm && s2 != lvl && cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign lvl_n = acc ? s2 : lvl;
  assign hit = REPEAT_EN && lvl && lvl_n && rc == HW'(HOLD_CYCLES - 1);
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      v <= '0;
      arm <= 1'b0;
      cnt <= '0;
      lvl <= 1'b0;
      rc <= '0;
      press_pulse <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      v <= {v[0], 1'b1};
      arm <= arm | (v[1] & ~s2);
      cnt <= (arm && s2 != lvl && !acc) ? cnt + 1'b1 : '0;
      lvl <= lvl_n;
      rc <= !lvl ? '0 : hit ? HW'(HOLD_CYCLES - REPEAT_CYCLES) : rc + 1'b1;
      press_pulse <= (acc && s2) || hit;
    end
endmodule

// File: rtl/signed_value_entry.sv
// signed_value_entry: button-driven saturating signed 8-bit value for the seven-segment driver
module signed_value_entry
  import sve_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  input  logic       BTN_LD,
  input  logic       BTN_CLR,
  input  logic [7:0] SW,
  output logic [7:0] C,
  output logic       C_UPD,
  output logic       SAT
);
  logic up, dn, ld, clr;
  logic [7:0] sw1, sw2, nxt;
  logic signed [8:0] c9, nxt9;
  op_t op;
  button_conditioner #(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES, 1'b1) u_up (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .btn_raw(BTN_UP), .press_pulse(up));
  button_conditioner #(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES, 1'b1) u_dn (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .btn_raw(BTN_DN), .press_pulse(dn));
  button_conditioner #(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES, 1'b0) u_ld (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .btn_raw(BTN_LD), .press_pulse(ld));
  button_conditioner #(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES, 1'b0) u_clr (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .btn_raw(BTN_CLR), .press_pulse(clr));
  // simultaneous UP and DN cancel; lower-priority pulses are simply dropped
  always_comb begin
    op = clr ? OP_CLR : ld ? OP_LD : (up && !dn) ? OP_INC : (dn && !up) ? OP_DEC : OP_NONE;
    c9 = $signed({C[7], C});
    nxt9 = op == OP_CLR ? 9'sd0 : op == OP_LD ? $signed({sw2[7], sw2}) :
           op == OP_INC ? c9 + 9'sd1 : op == OP_DEC ? c9 - 9'sd1 : c9;
    nxt = clamp9(nxt9);
  end
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      sw1 <= '0;
      sw2 <= '0;
      C <= C_ZERO;
      C_UPD <= 1'b0;
      SAT <= 1'b0;
    end else begin
      sw1 <= SW;
      sw2 <= sw1;
      C <= nxt;
      C_UPD <= nxt != C;
      SAT <= nxt == C_MAX || nxt == C_MIN;
    end
endmodule
